uart_dec_word_rx: RTL and testbench

UART_DEC_WORD_RX -- requirements
Module: uart_dec_word_rx

---
 rtl/uart_dec_word_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_dec_word_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_dec_word_rx.sv
// rtl/uart_dec_word_rx.sv - 8N1 UART receiver feeding a signed decimal word parser
module uart_dec_word_rx #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 512
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     uart_txd_in,
  output logic [WIDTH-1:0]         word_data,
  output logic                     word_valid,
  output logic [$clog2(DEPTH)-1:0] word_index,
  output logic                     frame_done,
  output logic                     framing_err,
  output logic                     parse_err,
  output logic                     range_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [CW-1:0]    HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [WIDTH-1:0] MAG_LIM  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_EMPTY, P_SIGN, P_DIGITS, P_DISCARD} p_state_t;

  rx_state_t        rx_state_q;
  p_state_t         p_state_q, p_state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             neg_q, neg_d, sat_q, sat_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [IDXW-1:0]  slot_q;
  logic             emit_d, perr_d;
  logic [WIDTH+3:0] prod_d;
  logic             pos_clamp;
  logic [WIDTH-1:0] emit_val;
  logic             emit_rerr;

  logic [WIDTH-1:0] word_data_q;
  logic [IDXW-1:0]  word_index_q;
  logic             word_valid_q, frame_done_q, framing_err_q, parse_err_q, range_err_q;

  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign word_index  = word_index_q;
  assign frame_done  = frame_done_q;
  assign framing_err = framing_err_q;
  assign parse_err   = parse_err_q;
  assign range_err   = range_err_q;

  assign prod_d    = {4'b0, mag_q} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, shift_q[3:0]};
  assign pos_clamp = mag_q > MAX_POS;
  assign emit_val  = neg_q ? (~mag_q + WIDTH'(1)) : (pos_clamp ? MAX_POS : mag_q);
  assign emit_rerr = sat_q | (!neg_q && pos_clamp);

  // Parser next state for the byte currently held in shift_q.
  always_comb begin
    p_state_d = p_state_q;
    neg_d     = neg_q;
    mag_d     = mag_q;
    sat_d     = sat_q;
    emit_d    = 1'b0;
    perr_d    = 1'b0;
    if (shift_q == 8'h0A) begin
      p_state_d = p_state_q;
    end else if (p_state_q == P_DISCARD) begin
      if (shift_q == 8'h0D) begin
        p_state_d = P_EMPTY;
        neg_d = 1'b0; mag_d = '0; sat_d = 1'b0;
      end
    end else if (shift_q == 8'h0D) begin
      if (p_state_q == P_SIGN) perr_d = 1'b1;
      if (p_state_q == P_DIGITS) emit_d = 1'b1;
      p_state_d = P_EMPTY;
      neg_d = 1'b0; mag_d = '0; sat_d = 1'b0;
    end else if (shift_q == 8'h2D && p_state_q == P_EMPTY) begin
      neg_d     = 1'b1;
      p_state_d = P_SIGN;
    end else if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      if (prod_d > {4'b0, MAG_LIM}) begin
        mag_d = MAG_LIM;
        sat_d = 1'b1;
      end else begin
        mag_d = prod_d[WIDTH-1:0];
      end
      p_state_d = P_DIGITS;
    end else begin
      perr_d    = 1'b1;
      p_state_d = P_DISCARD;
      neg_d = 1'b0; mag_d = '0; sat_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_state_q    <= R_IDLE;
      p_state_q     <= P_EMPTY;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      neg_q         <= 1'b0;
      sat_q         <= 1'b0;
      mag_q         <= '0;
      slot_q        <= '0;
      word_data_q   <= '0;
      word_index_q  <= '0;
      word_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      framing_err_q <= 1'b0;
      parse_err_q   <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      rx_meta_q     <= uart_txd_in;
      rx_sync_q     <= rx_meta_q;
      word_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      framing_err_q <= 1'b0;
      parse_err_q   <= 1'b0;
      range_err_q   <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) rx_state_q <= R_START;
        end
        R_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q      <= '0;
            rx_state_q <= R_IDLE;
            if (rx_sync_q) begin
              p_state_q   <= p_state_d;
              neg_q       <= neg_d;
              mag_q       <= mag_d;
              sat_q       <= sat_d;
              parse_err_q <= perr_d;
              if (emit_d) begin
                word_data_q  <= emit_val;
                word_valid_q <= 1'b1;
                range_err_q  <= emit_rerr;
                word_index_q <= slot_q;
                frame_done_q <= (slot_q == IDXW'(DEPTH - 1));
                slot_q       <= (slot_q == IDXW'(DEPTH - 1)) ? '0 : slot_q + IDXW'(1);
              end
            end else begin
              framing_err_q <= 1'b1;
              p_state_q     <= P_DISCARD;
              neg_q         <= 1'b0;
              mag_q         <= '0;
              sat_q         <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dec_word_rx.sv
// tb/tb_uart_dec_word_rx.sv - scoreboard bench for uart_dec_word_rx
module tb_uart_dec_word_rx;
  localparam int CPB = 8;
  localparam int W   = 16;
  localparam int D   = 4;

  logic         sysclk = 1'b0;
  logic         rst = 1'b1;
  logic         uart_txd_in = 1'b1;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic [1:0]   word_index;
  logic         frame_done, framing_err, parse_err, range_err;

  uart_dec_word_rx #(.CLKS_PER_BIT(CPB), .WIDTH(W), .DEPTH(D)) dut (
    .sysclk(sysclk), .rst(rst), .uart_txd_in(uart_txd_in),
    .word_data(word_data), .word_valid(word_valid), .word_index(word_index),
    .frame_done(frame_done), .framing_err(framing_err), .parse_err(parse_err),
    .range_err(range_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string        txt;
    bit           has_word;
    logic [W-1:0] data;
    bit           rerr;
    int           perr;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
    bit           rerr;
    bit           fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[13];
  int   n_chk = 0, n_fail = 0, perr_cnt = 0, ferr_cnt = 0, slot = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every word_valid must match the oldest pushed expectation.
  always @(negedge sysclk) begin
    if (!rst) begin
      if (parse_err) perr_cnt++;
      if (framing_err) ferr_cnt++;
      if (!word_valid) begin
        if (range_err) check("range_err_without_word", range_err, 1'b0);
        if (frame_done) check("frame_done_without_word", frame_done, 1'b0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_word", word_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", word_data, mon_e.data);
        check("word_index", word_index, mon_e.idx);
        check("range_err", range_err, mon_e.rerr);
        check("frame_done", frame_done, mon_e.fd);
      end
    end
  end

  task automatic drive_bit(logic v);
    uart_txd_in = v;
    repeat (CPB) @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b, logic stop_ok);
    @(posedge sysclk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    uart_txd_in = 1'b1;
    repeat (2 * CPB) @(posedge sysclk);
    #1;
  endtask

  task automatic run_vec(vec_t v);
    int   p0;
    exp_t e;
    p0 = perr_cnt;
    if (v.has_word) begin
      e.data = v.data;
      e.idx  = 2'(slot);
      e.rerr = v.rerr;
      e.fd   = (slot == D - 1);
      exp_q.push_back(e);
      slot = (slot + 1) % D;
    end
    for (int i = 0; i < v.txt.len(); i++) send_byte(v.txt[i], 1'b1);
    send_byte(8'h0D, 1'b1);
    check({"words_pending \"", v.txt, "\""}, exp_q.size(), 0);
    check({"parse_err_count \"", v.txt, "\""}, perr_cnt - p0, v.perr);
  endtask

  task automatic do_reset();
    uart_txd_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    exp_q.delete();
    slot = 0;
  endtask

  initial begin
    int   f0;
    vec_t v;
    vecs[0]  = '{"-123",   1'b1, 16'hFF85, 1'b0, 0};
    vecs[1]  = '{"40000",  1'b1, 16'h7FFF, 1'b1, 0};
    vecs[2]  = '{"-32768", 1'b1, 16'h8000, 1'b0, 0};
    vecs[3]  = '{"12a4",   1'b0, 16'h0000, 1'b0, 1};
    vecs[4]  = '{"5",      1'b1, 16'h0005, 1'b0, 0};
    vecs[5]  = '{"32768",  1'b1, 16'h7FFF, 1'b1, 0};
    vecs[6]  = '{"-99999", 1'b1, 16'h8000, 1'b1, 0};
    vecs[7]  = '{"",       1'b0, 16'h0000, 1'b0, 0};
    vecs[8]  = '{"-",      1'b0, 16'h0000, 1'b0, 1};
    vecs[9]  = '{"\n7",    1'b1, 16'h0007, 1'b0, 0};
    vecs[10] = '{"1-2",    1'b0, 16'h0000, 1'b0, 1};
    vecs[11] = '{"0",      1'b1, 16'h0000, 1'b0, 0};
    vecs[12] = '{"32767",  1'b1, 16'h7FFF, 1'b0, 0};

    repeat (3) @(posedge sysclk);
    #1;
    check("reset_word_data", word_data, 0);
    check("reset_word_index", word_index, 0);
    check("reset_pulses", {word_valid, frame_done, framing_err, parse_err, range_err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Low stop bit: the rest of that line is thrown away up to its CR.
    f0 = ferr_cnt;
    send_byte("1", 1'b0);
    check("framing_err_count", ferr_cnt - f0, 1);
    v = '{"2", 1'b0, 16'h0000, 1'b0, 0};
    run_vec(v);
    v = '{"3", 1'b1, 16'h0003, 1'b0, 0};
    run_vec(v);
    check("framing_err_single", ferr_cnt - f0, 1);

    // Reset while the second digit of "78" is in its data bits.
    send_byte("7", 1'b1);
    @(posedge sysclk); #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    uart_txd_in = 1'b1;
    rst = 1'b1;
    @(posedge sysclk); #1;
    rst = 1'b0;
    exp_q.delete();
    slot = 0;
    repeat (20 * CPB) @(posedge sysclk);
    #1;
    v = '{"9", 1'b1, 16'h0009, 1'b0, 0};
    run_vec(v);

    do_reset();
    for (int k = 1; k <= 5; k++) begin
      v.txt      = $sformatf("%0d", k);
      v.has_word = 1'b1;
      v.data     = W'(k);
      v.rerr     = 1'b0;
      v.perr     = 0;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
